shift_arbiter: RTL and testbench

Shares one 32-bit `barrel_shifter` (ports `d`, `sa`, `right`, `arith`, `sh`) between two independent requesters.
- Each requester issues shift operations over a valid/ready handshake.
- The arbiter selects one per cycle and latches its operands into a single operand register that drives the shared shifter.
- It presents the result, tagged with the requester ID, on a valid/ready result port.
- It sits between the ALU-side issue logic and the shared shift unit in the datapath.

---
 rtl/shift_arbiter.sv | 166 ++++++++++++++++
 tb/tb_shift_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two valid/ready requesters share one 32-bit barrel shifter
// through a single operand register and a one-entry tagged result slot.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req0_* / req1_*       requester handshakes and operands (d, sa, right, arith)
//   res_valid, res_ready  result slot handshake
//   res_data, res_id      shifter output and issuing requester
//
// Build option: define SHIFT_ARB_RR_EN for round-robin tie-break;
// undefined gives fixed priority to requester 0.

module barrel_shifter (
    input  logic [31:0] d,
    input  logic [4:0]  sa,
    input  logic        right,
    input  logic        arith,
    output logic [31:0] sh
);
    logic [31:0] lsh;
    logic [31:0] rsh;
    logic [31:0] fill_mask;

    always_comb begin
        lsh       = d << sa;
        rsh       = d >> sa;
        // Bits vacated by the right shift; set only for arithmetic fill.
        fill_mask = ~(32'hffff_ffff >> sa);
        if (right) begin
            sh = (arith && d[31]) ? (rsh | fill_mask) : rsh;
        end else begin
            sh = lsh;
        end
    end
endmodule

module shift_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_d,
    input  logic [4:0]  req0_sa,
    input  logic        req0_right,
    input  logic        req0_arith,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_d,
    input  logic [4:0]  req1_sa,
    input  logic        req1_right,
    input  logic        req1_arith,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_id
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e       state_q, state_d;
    logic [31:0] op_d_q, op_d_d;
    logic [4:0]  op_sa_q, op_sa_d;
    logic        op_right_q, op_right_d;
    logic        op_arith_q, op_arith_d;
    logic        res_id_q, res_id_d;
`ifdef SHIFT_ARB_RR_EN
    logic        last_id_q, last_id_d;
`endif

    logic accept_ok;
    logic pick1;
    logic fire;

    // Grant: pick1 selects requester 1, otherwise requester 0 if valid.
    always_comb begin
`ifdef SHIFT_ARB_RR_EN
        pick1 = req1_valid && (!req0_valid || !last_id_q);
`else
        pick1 = req1_valid && !req0_valid;
`endif
        accept_ok  = (state_q == EMPTY) || res_ready;
        req0_ready = req0_valid && !pick1 && accept_ok && !rst;
        req1_ready = pick1 && accept_ok && !rst;
        fire       = req0_ready || req1_ready;
    end

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next state: a simultaneous drain and accept stays FULL.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (fire) state_d = FULL;
            FULL:  if (!fire && res_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Slot outputs.
    always_comb begin
        res_valid = (state_q == FULL);
        res_id    = res_id_q;
    end

    // Operand register next values.
    always_comb begin
        op_d_d     = op_d_q;
        op_sa_d    = op_sa_q;
        op_right_d = op_right_q;
        op_arith_d = op_arith_q;
        res_id_d   = res_id_q;
`ifdef SHIFT_ARB_RR_EN
        last_id_d  = last_id_q;
`endif
        if (fire) begin
            op_d_d     = pick1 ? req1_d     : req0_d;
            op_sa_d    = pick1 ? req1_sa    : req0_sa;
            op_right_d = pick1 ? req1_right : req0_right;
            op_arith_d = pick1 ? req1_arith : req0_arith;
            res_id_d   = pick1;
`ifdef SHIFT_ARB_RR_EN
            last_id_d  = pick1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_d_q     <= 32'd0;
            op_sa_q    <= 5'd0;
            op_right_q <= 1'b0;
            op_arith_q <= 1'b0;
            res_id_q   <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
            // Requester 0 wins the first tie after reset.
            last_id_q  <= 1'b1;
`endif
        end else begin
            op_d_q     <= op_d_d;
            op_sa_q    <= op_sa_d;
            op_right_q <= op_right_d;
            op_arith_q <= op_arith_d;
            res_id_q   <= res_id_d;
`ifdef SHIFT_ARB_RR_EN
            last_id_q  <= last_id_d;
`endif
        end
    end

    barrel_shifter u_shifter (
        .d     (op_d_q),
        .sa    (op_sa_q),
        .right (op_right_q),
        .arith (op_arith_q),
        .sh    (res_data)
    );
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed vectors; expected results are queued on accept
// and checked by a monitor whenever a result is consumed.

module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_right, req0_arith;
    logic [31:0] req0_d;
    logic [4:0]  req0_sa;
    logic        req1_valid, req1_ready, req1_right, req1_arith;
    logic [31:0] req1_d;
    logic [4:0]  req1_sa;
    logic        res_valid, res_ready, res_id;
    logic [31:0] res_data;

    typedef struct {
        logic [31:0] data;
        logic        id;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    shift_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_d     (req0_d),
        .req0_sa    (req0_sa),
        .req0_right (req0_right),
        .req0_arith (req0_arith),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_d     (req1_d),
        .req1_sa    (req1_sa),
        .req1_right (req1_right),
        .req1_arith (req1_arith),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every negedge with valid && ready is one consumed result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("res_data", res_data, e.data);
                    chk("res_id", {31'd0, res_id}, {31'd0, e.id});
                end
            end
        end
    end

    // Issue one operation on a port, wait for ready, queue its result.
    task automatic issue(input logic port, input logic [31:0] d,
                         input logic [4:0] sa, input logic r, input logic a,
                         input logic [31:0] exp);
        bit   got = 0;
        exp_t e;
        if (!port) begin
            req0_d = d; req0_sa = sa; req0_right = r; req0_arith = a;
            req0_valid = 1'b1;
        end else begin
            req1_d = d; req1_sa = sa; req1_right = r; req1_arith = a;
            req1_valid = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((!port && req0_ready) || (port && req1_ready)) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            e.data = exp;
            e.id   = port;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (got) chk("latency_valid", {31'd0, res_valid}, 32'd1);
    endtask

    initial begin
        exp_t e;
        logic [31:0] held_data;
        rst = 1'b1;
        res_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_d = 32'h0; req0_sa = 5'd0; req0_right = 1'b0; req0_arith = 1'b0;
        req1_d = 32'h0; req1_sa = 5'd0; req1_right = 1'b0; req1_arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_id", {31'd0, res_id}, 32'd0);
        chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(1'b0, 32'hff0000ff, 5'd8, 1'b0, 1'b0, 32'h0000ff00);
        issue(1'b1, 32'hff0000ff, 5'd8, 1'b1, 1'b0, 32'h00ff0000);
        issue(1'b1, 32'hff0000ff, 5'd8, 1'b1, 1'b1, 32'hffff0000);
        issue(1'b1, 32'hff0000ff, 5'd0, 1'b1, 1'b1, 32'hff0000ff);
        issue(1'b0, 32'h80000001, 5'd1, 1'b0, 1'b1, 32'h00000002);
        issue(1'b1, 32'h7000000f, 5'd31, 1'b1, 1'b1, 32'h00000000);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: slot held full, second request must wait.
        res_ready = 1'b0;
        issue(1'b0, 32'h00000003, 5'd4, 1'b0, 1'b0, 32'h00000030);
        req0_d = 32'h00001000; req0_sa = 5'd12; req0_right = 1'b1;
        req0_arith = 1'b0; req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_no_ready", {31'd0, req0_ready}, 32'd0);
            chk("bp_data_hold", res_data, 32'h00000030);
            chk("bp_id_hold", {31'd0, res_id}, 32'd0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_same_cycle", {31'd0, req0_ready}, 32'd1);
        e.data = 32'h00000001; e.id = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("bp_valid_stays", {31'd0, res_valid}, 32'd1);
        held_data = res_data;
        chk("bp_new_data", held_data, 32'h00000001);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_drained", {31'd0, res_valid}, 32'd0);

        // Reset with a held result and both requesters valid.
        res_ready = 1'b0;
        req0_d = 32'h00000001; req0_sa = 5'd1; req0_right = 1'b0;
        req0_arith = 1'b0;
        req1_d = 32'h80000000; req1_sa = 5'd4; req1_right = 1'b1;
        req1_arith = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_full", {31'd0, res_valid}, 32'd1);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("mid_rst_rdy1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b1;

        // Continuous contention from the first edge after reset.
        for (int i = 0; i < 6; i++) begin
            logic g;
`ifdef SHIFT_ARB_RR_EN
            g = i[0];
`else
            g = 1'b0;
`endif
            @(negedge clk);
            chk("grant_rdy0", {31'd0, req0_ready}, {31'd0, ~g});
            chk("grant_rdy1", {31'd0, req1_ready}, {31'd0, g});
            e.data = g ? 32'hf8000000 : 32'h00000002;
            e.id = g;
            q.push_back(e);
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 32'd0);
        chk("end_idle", {31'd0, res_valid}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
